// File: rtl/apb_pkg.sv
// Shared types and helpers for the APB register-file peripheral.
// Bus widths, FSM states and address-to-index decode.
package apb_pkg;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;
  localparam int REG_IDX_W  = 6;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } slv_state_t;

  function automatic logic [REG_IDX_W-1:0] addr_to_index(
    input logic [APB_ADDR_W-1:0] addr
  );
    return addr[7:2];
  endfunction

endpackage

// File: rtl/apb_slave_regfile_if.sv
// APB3 bus bundle between a requester and the register file.
// clk and rst_n stay outside as plain ports.
interface apb_slave_regfile_if;
  import apb_pkg::*;

  logic [APB_ADDR_W-1:0] PADDR;
  logic                  PWRITE;
  logic                  PSEL;
  logic                  PENABLE;
  logic [APB_DATA_W-1:0] PWDATA;
  logic [APB_DATA_W-1:0] PRDATA;
  logic                  PREADY;
  logic                  PSLVERR;

  modport master (
    output PADDR, PWRITE, PSEL, PENABLE, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PADDR, PWRITE, PSEL, PENABLE, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );

endinterface

// File: rtl/apb_wait_timer.sv
// Loadable down-counter that paces the access-phase wait states.
// done is high once the count has reached zero.
module apb_wait_timer #(
  parameter  int WAIT_CYCLES = 2,
  localparam int W = (WAIT_CYCLES > 0) ?
                     $clog2(WAIT_CYCLES + 1) : 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         done
);

  logic [W-1:0] cnt;

  // load wins over count; counting stops at zero
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/apb_slave_regfile.sv
// APB3 completer: RW word registers, a read-only write counter
// in the top slot, and a fixed number of access-phase wait states.
module apb_slave_regfile
  import apb_pkg::*;
#(
  parameter int          NUM_REGS    = 8,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] RESET_VAL   = 32'h0000_0000
) (
  input logic               clk,
  input logic               rst_n,
  apb_slave_regfile_if.slave bus
);

  localparam int TW = (WAIT_CYCLES > 0) ?
                      $clog2(WAIT_CYCLES + 1) : 1;
  localparam int LOADV = (WAIT_CYCLES > 0) ?
                         WAIT_CYCLES - 1 : 0;
  localparam logic [REG_IDX_W-1:0] CNT_IDX =
    REG_IDX_W'(NUM_REGS - 1);
  localparam logic [REG_IDX_W:0] NREGS =
    (REG_IDX_W + 1)'(NUM_REGS);

  slv_state_t state, next_state;

  logic                 write_q;
  logic                 err_q;
  logic [REG_IDX_W-1:0] index_q;
  logic [31:0]          wdata_q;
  logic [31:0]          rdata_q;

  logic [31:0] regs [NUM_REGS-1];
  logic [31:0] wcnt;

  logic                 setup;
  logic                 do_write;
  logic                 t_load;
  logic                 t_en;
  logic                 t_done;
  logic [REG_IDX_W-1:0] idx;
  logic                 err;
  logic                 src_err;
  logic                 src_wr;
  logic [REG_IDX_W-1:0] src_idx;
  logic [31:0]          rd_val;

  apb_wait_timer #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (t_load),
    .load_val(TW'(LOADV)),
    .en      (t_en),
    .done    (t_done)
  );

  // address decode of the live bus; used at setup
  always_comb begin
    idx = addr_to_index(bus.PADDR);
    err = (bus.PADDR[1:0] != 2'b00)
        | (bus.PADDR[31:8] != 24'h0)
        | ({1'b0, idx} >= NREGS)
        | (bus.PWRITE && idx == CNT_IDX);
  end

  // zero-wait builds enter RESP straight from setup,
  // so the read source must bypass the holding regs
  always_comb begin
    src_err = setup ? err : err_q;
    src_wr  = setup ? bus.PWRITE : write_q;
    src_idx = setup ? idx : index_q;
    rd_val  = '0;
    for (int i = 0; i < NUM_REGS - 1; i++) begin
      if (src_idx == REG_IDX_W'(i)) rd_val = regs[i];
    end
    if (src_idx == CNT_IDX) rd_val = wcnt;
  end

  // next-state and control strobes
  always_comb begin
    next_state = state;
    setup      = 1'b0;
    do_write   = 1'b0;
    t_load     = 1'b0;
    t_en       = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.PSEL && !bus.PENABLE) begin
          setup  = 1'b1;
          t_load = 1'b1;
          next_state = (WAIT_CYCLES == 0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (!bus.PSEL) begin
          next_state = IDLE;
        end else if (t_done) begin
          next_state = RESP;
        end else begin
          t_en = 1'b1;
        end
      end
      RESP: begin
        next_state = IDLE;
        do_write = bus.PSEL && bus.PENABLE
                && bus.PWRITE && !err_q;
      end
      default: next_state = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // holding regs captured during the setup phase
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      write_q <= 1'b0;
      err_q   <= 1'b0;
      index_q <= '0;
      wdata_q <= '0;
    end else if (setup) begin
      write_q <= bus.PWRITE;
      err_q   <= err;
      index_q <= idx;
      wdata_q <= bus.PWDATA;
    end
  end

  // registered read data, loaded on the way into RESP
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (next_state == RESP) begin
      rdata_q <= (src_err || src_wr) ? '0 : rd_val;
    end else begin
      rdata_q <= '0;
    end
  end

  // register bank and write counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS - 1; i++) begin
        regs[i] <= RESET_VAL;
      end
      wcnt <= '0;
    end else if (do_write) begin
      for (int i = 0; i < NUM_REGS - 1; i++) begin
        if (index_q == REG_IDX_W'(i)) regs[i] <= wdata_q;
      end
      wcnt <= wcnt + 32'd1;
    end
  end

  assign bus.PREADY  = (state == RESP);
  assign bus.PSLVERR = (state == RESP) && err_q;
  assign bus.PRDATA  = (state == RESP) ? rdata_q : '0;

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Bench for apb_slave_regfile: a 2-wait and a 0-wait instance,
// directed transfers with a queue-based response monitor.
module tb_apb_slave_regfile;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          wt;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic started = 1'b0;
  logic done = 1'b0;

  logic [31:0] paddr   [2];
  logic [31:0] pwdata  [2];
  logic        pwrite  [2];
  logic        psel    [2];
  logic        penable [2];
  logic [31:0] rdata   [2];
  logic        ready   [2];
  logic        slverr  [2];

  exp_t q0[$];
  exp_t q1[$];
  int   acc [2];

  int n_vec = 0;
  int n_bad = 0;

  apb_slave_regfile_if bus0 ();
  apb_slave_regfile_if bus1 ();

  assign bus0.PADDR   = paddr[0];
  assign bus0.PWDATA  = pwdata[0];
  assign bus0.PWRITE  = pwrite[0];
  assign bus0.PSEL    = psel[0];
  assign bus0.PENABLE = penable[0];
  assign rdata[0]     = bus0.PRDATA;
  assign ready[0]     = bus0.PREADY;
  assign slverr[0]    = bus0.PSLVERR;

  assign bus1.PADDR   = paddr[1];
  assign bus1.PWDATA  = pwdata[1];
  assign bus1.PWRITE  = pwrite[1];
  assign bus1.PSEL    = psel[1];
  assign bus1.PENABLE = penable[1];
  assign rdata[1]     = bus1.PRDATA;
  assign ready[1]     = bus1.PREADY;
  assign slverr[1]    = bus1.PSLVERR;

  apb_slave_regfile #(
    .NUM_REGS(8), .WAIT_CYCLES(2),
    .RESET_VAL(32'h0000_0000)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0.slave)
  );

  apb_slave_regfile #(
    .NUM_REGS(8), .WAIT_CYCLES(0),
    .RESET_VAL(32'h0000_0000)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int b,
                     input logic [31:0] act,
                     input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s bus%0d: got %h want %h",
               nm, b, act, req);
    end
  endtask

  // response monitor: pops one expectation per PREADY
  always @(negedge clk) begin
    if (done) begin
      foreach (q0[i]) begin
        n_bad++;
        $display("FAIL missing_resp bus0: got none want %h",
                 q0[i].rd);
      end
      foreach (q1[i]) begin
        n_bad++;
        $display("FAIL missing_resp bus1: got none want %h",
                 q1[i].rd);
      end
      $display("== %0d vectors applied, %0d miscompares ==",
               n_vec, n_bad);
      $finish;
    end else if (started) begin
      for (int b = 0; b < 2; b++) begin
        if (ready[b]) begin
          exp_t e;
          logic have;
          have = (b == 0) ? (q0.size() != 0)
                          : (q1.size() != 0);
          if (!have) begin
            n_vec++;
            n_bad++;
            $display("FAIL unexpected_ready bus%0d: got 1 want 0",
                     b);
          end else begin
            if (b == 0) e = q0.pop_front();
            else        e = q1.pop_front();
            chk("prdata", b, rdata[b], e.rd);
            chk("pslverr", b, {31'b0, slverr[b]},
                {31'b0, e.err});
            chk("wait_states", b, acc[b], e.wt);
          end
          acc[b] = 0;
        end else begin
          chk("idle_out", b,
              rdata[b] | {31'b0, slverr[b]}, 32'h0);
          if (psel[b] && penable[b]) acc[b]++;
          else acc[b] = 0;
        end
      end
    end
  end

  task automatic xfer(input int b, input logic wr,
                      input logic [31:0] a,
                      input logic [31:0] d,
                      input logic [31:0] erd,
                      input logic eerr);
    exp_t e;
    int wt;
    wt = (b == 0) ? 2 : 0;
    e.rd = erd; e.err = eerr; e.wt = wt;
    @(posedge clk); #1;
    psel[b] = 1'b1; penable[b] = 1'b0;
    pwrite[b] = wr; paddr[b] = a; pwdata[b] = d;
    if (b == 0) q0.push_back(e);
    else        q1.push_back(e);
    @(posedge clk); #1;
    penable[b] = 1'b1;
    repeat (wt + 1) @(posedge clk);
    #1;
    psel[b] = 1'b0; penable[b] = 1'b0;
  endtask

  task automatic rd(input int b, input logic [31:0] a,
                    input logic [31:0] erd,
                    input logic eerr);
    xfer(b, 1'b0, a, 32'h0, erd, eerr);
  endtask

  task automatic wr(input int b, input logic [31:0] a,
                    input logic [31:0] d, input logic eerr);
    xfer(b, 1'b1, a, d, 32'h0, eerr);
  endtask

  initial begin
    for (int b = 0; b < 2; b++) begin
      paddr[b] = '0; pwdata[b] = '0; pwrite[b] = 1'b0;
      psel[b] = 1'b0; penable[b] = 1'b0; acc[b] = 0;
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    started = 1'b1;

    rd(0, 32'h00, 32'h0, 1'b0);
    wr(0, 32'h04, 32'hDEAD_BEEF, 1'b0);
    rd(0, 32'h04, 32'hDEAD_BEEF, 1'b0);
    rd(0, 32'h1C, 32'h1, 1'b0);
    wr(0, 32'h1C, 32'h5, 1'b1);
    rd(0, 32'h20, 32'h0, 1'b1);
    rd(0, 32'h02, 32'h0, 1'b1);
    wr(0, 32'h104, 32'h7, 1'b1);
    rd(0, 32'h1C, 32'h1, 1'b0);
    rd(0, 32'h04, 32'hDEAD_BEEF, 1'b0);

    // access phase with no setup: must be ignored
    @(posedge clk); #1;
    psel[0] = 1'b1; penable[0] = 1'b1;
    paddr[0] = 32'h04; pwrite[0] = 1'b1;
    pwdata[0] = 32'h1111_1111;
    repeat (3) @(posedge clk);
    #1 psel[0] = 1'b0; penable[0] = 1'b0;
    rd(0, 32'h04, 32'hDEAD_BEEF, 1'b0);

    // abort in the first wait cycle
    @(posedge clk); #1;
    psel[0] = 1'b1; penable[0] = 1'b0;
    pwrite[0] = 1'b1; paddr[0] = 32'h0C;
    pwdata[0] = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    psel[0] = 1'b0;
    rd(0, 32'h0C, 32'h0, 1'b0);
    rd(0, 32'h1C, 32'h1, 1'b0);

    // reset during the wait phase of a write
    @(posedge clk); #1;
    psel[0] = 1'b1; penable[0] = 1'b0;
    pwrite[0] = 1'b1; paddr[0] = 32'h10;
    pwdata[0] = 32'hAAAA_5555;
    @(posedge clk); #1;
    penable[0] = 1'b1; rst_n = 1'b0;
    @(posedge clk); #1;
    psel[0] = 1'b0; penable[0] = 1'b0; rst_n = 1'b1;
    rd(0, 32'h10, 32'h0, 1'b0);
    rd(0, 32'h04, 32'h0, 1'b0);
    rd(0, 32'h1C, 32'h0, 1'b0);

    wr(0, 32'h14, 32'h0F0F_0F0F, 1'b0);
    rd(0, 32'h14, 32'h0F0F_0F0F, 1'b0);
    rd(0, 32'h1C, 32'h1, 1'b0);

    // counter wrap
    @(negedge clk);
    force dut0.wcnt = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut0.wcnt;
    rd(0, 32'h1C, 32'hFFFF_FFFF, 1'b0);
    wr(0, 32'h18, 32'h0000_0001, 1'b0);
    rd(0, 32'h1C, 32'h0, 1'b0);
    rd(0, 32'h18, 32'h1, 1'b0);

    // zero-wait instance
    wr(1, 32'h08, 32'h1234_5678, 1'b0);
    rd(1, 32'h08, 32'h1234_5678, 1'b0);
    rd(1, 32'h1C, 32'h1, 1'b0);
    wr(1, 32'h1C, 32'h9, 1'b1);
    rd(1, 32'h03, 32'h0, 1'b1);
    rd(1, 32'h1C, 32'h1, 1'b0);

    repeat (4) @(posedge clk);
    done = 1'b1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
